// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   dmem_state_t : sequencer states (IDLE -> ISSUE -> DONE)
//   gnt_id_t     : index of the granted master (0 = CPU, 1 = debug/DMA)
//   WORD_SHIFT   : byte-address to word-index shift
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } dmem_state_t;

  typedef logic gnt_id_t;

  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter, purely combinational.
//   i_req        : request vector, bit n = master n
//   i_last_grant : master granted by the previous completed transaction
//   o_gnt        : one-hot grant (all zero when nothing requests)
module rr_arb2
  import dmem_pkg::*;
(
  input  logic [1:0] i_req,
  input  gnt_id_t    i_last_grant,
  output logic [1:0] o_gnt
);
  always_comb begin
    o_gnt = i_req;
    // On contention the master that did not win last time goes first.
    if (i_req == 2'b11) o_gnt = i_last_grant ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer in front of the word-addressed data memory.
// Each access takes IDLE (grant + latch + address check), ISSUE (one-cycle
// rd or wr strobe, or nothing on an illegal address) and DONE (ack pulse).
//   clk, rst_n           : clock, async active-low reset
//   mN_req/we/addr/wdata : master N request and fields (held until ack)
//   mN_ack/err/rdata     : master N completion pulse, error flag, load data
//   mem_rd/mem_wr        : mutually exclusive memory strobes
//   mem_addr/mem_wdata   : memory address / store data (held between strobes)
//   mem_rdata            : combinational memory read data
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam logic [ADDR_W-1:0] W_LIMIT = ADDR_W'(MEM_WORDS);

  dmem_state_t       r_state, w_next;
  gnt_id_t           r_gid, r_last, w_gid;
  logic              r_we, r_err;
  logic [ADDR_W-1:0] r_maddr;
  logic [DATA_W-1:0] r_mwdata, r_rdata0, r_rdata1, w_cap;
  logic [1:0]        w_req, w_gnt;
  logic              w_we, w_err;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_req = {m1_req, m0_req};

  rr_arb2 u_arb (
    .i_req       (w_req),
    .i_last_grant(r_last),
    .o_gnt       (w_gnt)
  );

  assign w_gid   = gnt_id_t'(w_gnt == 2'b10);
  assign w_we    = w_gid ? m1_we    : m0_we;
  assign w_addr  = w_gid ? m1_addr  : m0_addr;
  assign w_wdata = w_gid ? m1_wdata : m0_wdata;
  assign w_err   = (w_addr[1:0] != 2'b00) || ((w_addr >> WORD_SHIFT) >= W_LIMIT);
  assign w_cap   = r_err ? '0 : mem_rdata;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_next = ISSUE;
      ISSUE:   w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Latches and per-port read-data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gid    <= 1'b0;
      r_last   <= 1'b1;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_maddr  <= '0;
      r_mwdata <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      case (r_state)
        IDLE: if (|w_req) begin
          r_gid <= w_gid;
          r_we  <= w_we;
          r_err <= w_err;
          // Memory-side address/data only move for a legal access, so they
          // stay put across error transactions where no strobe is raised.
          if (!w_err) begin
            r_maddr <= w_addr;
            if (w_we) r_mwdata <= w_wdata;
          end
        end
        ISSUE: if (r_err || !r_we) begin
          if (r_gid) r_rdata1 <= w_cap;
          else       r_rdata0 <= w_cap;
        end
        DONE:    r_last <= r_gid;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so an async reset drops strobes at once.
  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    m0_ack = 1'b0;
    m1_ack = 1'b0;
    m0_err = 1'b0;
    m1_err = 1'b0;
    case (r_state)
      ISSUE: if (!r_err) begin
        mem_rd = !r_we;
        mem_wr = r_we;
      end
      DONE: begin
        m0_ack = !r_gid;
        m1_ack = r_gid;
        m0_err = !r_gid && r_err;
        m1_err = r_gid && r_err;
      end
      default: ;
    endcase
  end

  assign mem_addr  = r_maddr;
  assign mem_wdata = r_mwdata;
  assign m0_rdata  = r_rdata0;
  assign m1_rdata  = r_rdata1;
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int DATA_W = 32, ADDR_W = 32, MEM_WORDS = 1024;

  logic clk = 1'b0, rst_n;
  logic m0_req, m0_we, m0_ack, m0_err, m1_req, m1_we, m1_ack, m1_err;
  logic [ADDR_W-1:0] m0_addr, m1_addr, mem_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_wdata, mem_rdata;
  logic mem_rd, mem_wr;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Environment memory, driven only by the DUT strobes.
  logic [31:0] env_mem [MEM_WORDS];
  assign mem_rdata = ((mem_addr >> 2) < MEM_WORDS) ? env_mem[mem_addr[11:2]] : '0;
  always @(posedge clk)
    if (mem_wr && (mem_addr >> 2) < MEM_WORDS) env_mem[mem_addr[11:2]] <= mem_wdata;

  // Transaction-level reference model.
  logic [31:0] ref_mem [MEM_WORDS];
  bit          last_g;
  bit          pend [2];
  bit          p_we [2];
  logic [31:0] p_addr [2], p_data [2], exp_rd [2];
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_data[0];
    m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_data[1];
  endtask

  task automatic post(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
    apply();
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'($urandom_range(0, 31) * 4 + $urandom_range(1, 3));
    if (r == 1) return 32'((MEM_WORDS + $urandom_range(0, 100)) * 4);
    return 32'($urandom_range(0, 31) * 4);
  endfunction

  // Called at a negedge with the DUT idle; runs one grant to completion.
  task automatic run_txn();
    int w, idx;
    bit e;
    logic [31:0] a;
    if (!pend[0] && !pend[1]) return;
    if (pend[0] && pend[1]) w = last_g ? 0 : 1;
    else                    w = pend[0] ? 0 : 1;
    a   = p_addr[w];
    e   = (a[1:0] != 2'b00) || ((a >> 2) >= MEM_WORDS);
    idx = int'(a >> 2);
    @(posedge clk); @(negedge clk);
    chk("rd_strobe", 64'(mem_rd), 64'(!e && !p_we[w]));
    chk("wr_strobe", 64'(mem_wr), 64'(!e && p_we[w]));
    chk("strobe_excl", 64'(mem_rd & mem_wr), 64'(0));
    chk("early_ack", 64'({m1_ack, m0_ack}), 64'(0));
    if (!e) chk("mem_addr", 64'(mem_addr), 64'(a));
    if (!e && p_we[w]) chk("mem_wdata", 64'(mem_wdata), 64'(p_data[w]));
    if (e)             exp_rd[w] = '0;
    else if (p_we[w])  ref_mem[idx] = p_data[w];
    else               exp_rd[w] = ref_mem[idx];
    @(posedge clk); @(negedge clk);
    chk("ack", 64'({m1_ack, m0_ack}), (w == 1) ? 64'd2 : 64'd1);
    chk("err", 64'({m1_err, m0_err}), e ? ((w == 1) ? 64'd2 : 64'd1) : 64'd0);
    chk("rdata0", 64'(m0_rdata), 64'(exp_rd[0]));
    chk("rdata1", 64'(m1_rdata), 64'(exp_rd[1]));
    chk("strobe_in_ack", 64'({mem_rd, mem_wr}), 64'(0));
    last_g  = (w == 1);
    pend[w] = 1'b0;
    apply();
    @(posedge clk); @(negedge clk);
    chk("ack_pulse", 64'({m1_ack, m0_ack}), 64'(0));
  endtask

  initial begin
    logic [31:0] v, old;
    rst_n = 1'b0;
    pend = '{0, 0}; p_we = '{0, 0};
    p_addr = '{0, 0}; p_data = '{0, 0}; exp_rd = '{0, 0};
    last_g = 1'b1;
    apply();
    for (int i = 0; i < MEM_WORDS; i++) begin
      v = $urandom;
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    env_mem[2] = 32'h2; ref_mem[2] = 32'h2;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", 64'({mem_rd, mem_wr}), 64'(0));
    chk("rst_acks", 64'({m1_ack, m0_ack, m1_err, m0_err}), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_rdata", 64'({m1_rdata, m0_rdata}), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    // Contention from reset: both always requesting, loads only.
    for (int k = 0; k < 4; k++) begin
      if (!pend[0]) post(0, 1'b0, 32'(k * 4 + 64), 0);
      if (!pend[1]) post(1, 1'b0, 32'(k * 4 + 96), 0);
      run_txn();
    end
    while (pend[0] || pend[1]) run_txn();

    post(0, 1'b0, 32'd8, 0);                      run_txn();
    post(1, 1'b1, 32'h40, 32'hDEADBEEF);          run_txn();
    post(1, 1'b0, 32'h40, 0);                     run_txn();
    chk("store_load", 64'(m1_rdata), 64'h0000_0000_DEAD_BEEF);
    post(0, 1'b0, 32'h5, 0);                      run_txn();
    post(0, 1'b1, 32'd4096, 32'h1234);            run_txn();

    for (int k = 0; k < 80; k++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 1) == 1)
          post(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      run_txn();
    end
    while (pend[0] || pend[1]) run_txn();

    // Reset while a store is in ISSUE.
    old = env_mem[32];
    post(1, 1'b1, 32'h80, ~old);
    @(posedge clk); #1;
    chk("issue_wr", 64'(mem_wr), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_drop", 64'({mem_rd, mem_wr}), 64'(0));
    pend[1] = 1'b0;
    apply();
    @(posedge clk); @(negedge clk);
    chk("rst_no_ack", 64'({m1_ack, m0_ack}), 64'(0));
    chk("rst_no_store", 64'(env_mem[32]), 64'(old));
    rst_n = 1'b1;
    last_g = 1'b1;
    exp_rd = '{0, 0};
    post(0, 1'b0, 32'h80, 0);                     run_txn();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
